divider_controller: RTL and testbench

Multi-cycle sequencer for the MIPS DIV/DIVU unit. Accepts one divide request from the execute stage and runs a radix-2 restoring division, one quotient bit per clock, using an internal step counter. It applies sign pre- and post-processing and divide-by-zero handling. It returns quotient (LO) and remainder (HI) with a one-cycle completion pulse; the pipeline stalls on Busy.

---
 rtl/div_pkg.sv | 21 ++
 rtl/divider_controller_if.sv | 24 ++
 rtl/div_step_counter.sv | 39 +++
 rtl/divider_controller.sv | 174 +++++++++++++++++
 tb/tb_divider_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU sequencer.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   // Quotient reported for a zero divisor: all ones, as the MIPS core expects.
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ITER  = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } div_state_t;

   function automatic logic is_busy_state(input div_state_t s);
      return (s == LOAD) || (s == ITER) || (s == FIXUP);
   endfunction

endpackage

// File: rtl/divider_controller_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface divider_controller_if #(
   parameter int WIDTH = div_pkg::DIV_WIDTH
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/div_step_counter.sv
// Loadable down counter that paces the one-bit-per-clock division loop.
import div_pkg::*;

module div_step_counter #(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          en,
   input  logic [CW-1:0] load_value,
   output logic          zero
);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // Load has priority; the count parks at zero instead of wrapping.
   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = load_value;
      end else if (en && (count_reg != '0)) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/divider_controller.sv
// Radix-2 restoring DIV/DIVU sequencer: sign handling, divide-by-zero result,
// one quotient bit per clock, registered results with a one-cycle Done pulse.
import div_pkg::*;

module divider_controller #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   divider_controller_if.slave  bus
);

   localparam int               CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO_Q    = {WIDTH{DIV_ZERO_QUOTIENT[0]}};

   div_state_t       state_reg;
   div_state_t       state_next;
   logic             busy_reg;
   logic             busy_next;
   logic             done_reg;
   logic             done_next;

   logic [WIDTH-1:0] dividend_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic             signed_reg;
   logic [WIDTH-1:0] d_mag_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] q_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             div_zero_reg;

   logic             divisor_is_zero;
   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_step;

   logic             ctr_load;
   logic             ctr_en;
   logic             step_zero;

   div_step_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_step_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (ctr_load),
      .en         (ctr_en),
      .load_value (LAST_STEP),
      .zero       (step_zero)
   );

   // State register; busy/done are registered from the next state so no
   // output is decoded combinationally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = LOAD;
         LOAD:    state_next = divisor_is_zero ? DONE : ITER;
         ITER:    if (step_zero) state_next = FIXUP;
         FIXUP:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_next = is_busy_state(state_next);
      done_next = (state_next == DONE);
      ctr_load  = (state_reg == LOAD) && !divisor_is_zero;
      ctr_en    = (state_reg == ITER);
   end

   // Magnitudes: in signed mode a set MSB means negative. The most negative
   // value maps to itself, which is the correct unsigned magnitude.
   always_comb begin
      divisor_is_zero = (divisor_reg == '0);
      dividend_neg    = signed_reg & dividend_reg[WIDTH-1];
      divisor_neg     = signed_reg & divisor_reg[WIDTH-1];
      dividend_mag    = dividend_neg ? -dividend_reg : dividend_reg;
      divisor_mag     = divisor_neg  ? -divisor_reg  : divisor_reg;
   end

   // One restoring step: shift {R,Q} left, try subtracting the divisor at
   // WIDTH+1 bits, keep the difference when it did not go negative.
   always_comb begin
      r_shift = {r_reg, q_reg[WIDTH-1]};
      trial   = r_shift - {1'b0, d_mag_reg};
      if (!trial[WIDTH]) begin
         r_step = trial[WIDTH-1:0];
         q_step = {q_reg[WIDTH-2:0], 1'b1};
      end else begin
         r_step = r_shift[WIDTH-1:0];
         q_step = {q_reg[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dividend_reg  <= '0;
         divisor_reg   <= '0;
         signed_reg    <= 1'b0;
         d_mag_reg     <= '0;
         r_reg         <= '0;
         q_reg         <= '0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         div_zero_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  dividend_reg <= bus.dividend;
                  divisor_reg  <= bus.divisor;
                  signed_reg   <= bus.signed_op;
               end
            end
            LOAD: begin
               if (divisor_is_zero) begin
                  quotient_reg  <= ZERO_Q;
                  remainder_reg <= dividend_reg;
                  div_zero_reg  <= 1'b1;
               end else begin
                  q_reg     <= dividend_mag;
                  d_mag_reg <= divisor_mag;
                  r_reg     <= '0;
                  neg_q_reg <= dividend_neg ^ divisor_neg;
                  neg_r_reg <= dividend_neg;
               end
            end
            ITER: begin
               r_reg <= r_step;
               q_reg <= q_step;
            end
            FIXUP: begin
               quotient_reg  <= neg_q_reg ? -q_reg : q_reg;
               remainder_reg <= neg_r_reg ? -r_reg : r_reg;
               div_zero_reg  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.quotient  = quotient_reg;
   assign bus.remainder = remainder_reg;
   assign bus.div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divider_controller.sv
// Self-checking bench: directed literal cases plus randomized traffic against an
// arithmetic reference model, compared on every cycle.
module tb_divider_controller;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   divider_controller_if #(.WIDTH(W)) dif ();

   divider_controller #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, truncating division like DIV/DIVU.
   function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
      longint sa;
      longint sb;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
         return;
      end
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      dz = 1'b0;
   endfunction

   // Timeline model: accepted request -> busy for L cycles, then one done cycle.
   int             m_cnt = 0;
   bit             m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;
   logic [W-1:0]   m_q = '0, m_r = '0, p_q = '0, p_r = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt = 0; m_busy = 0; m_done = 0; m_q = '0; m_r = '0; m_dz = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (dif.start) begin
         ref_div(dif.signed_op, dif.dividend, dif.divisor, p_q, p_r, p_dz);
         m_busy = 1;
         m_cnt  = p_dz ? 1 : W + 2;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cycle {busy,done,dz,q,r}",
               {dif.busy, dif.done, dif.div_zero, dif.quotient, dif.remainder},
               {m_busy, m_done, m_dz, m_q, m_r});
      end
   end

   task automatic run_op(input string name, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input int elat);
      int lat;
      @(negedge clk);
      dif.start = 1'b1; dif.signed_op = s; dif.dividend = a; dif.divisor = b;
      @(negedge clk);
      dif.start = 1'b0;
      lat = 0;
      while (!dif.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      $display("op %s: lat=%0d q=%h r=%h dz=%0d", name, lat, dif.quotient, dif.remainder, dif.div_zero);
      check({name, " latency"}, lat, elat);
      check({name, " quotient"}, dif.quotient, eq);
      check({name, " remainder"}, dif.remainder, er);
      check({name, " divzero"}, dif.div_zero, edz);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0:       v = '0;
         1:       v = 32'd1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         4:       v = 32'h7FFF_FFFF;
         5:       v = W'($urandom_range(0, 255));
         default: v = $urandom();
      endcase
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global timeout");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int pulses;
      dif.start = 1'b0; dif.signed_op = 1'b0; dif.dividend = '0; dif.divisor = '0;
      @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset busy", dif.busy, 1'b0);
      check("reset quotient", dif.quotient, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("DIVU 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      run_op("DIV -100/7", 1'b1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
      run_op("DIV 100/-7", 1'b1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
      run_op("DIVU max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
      run_op("DIV ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
      run_op("DIVU 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
      run_op("DIVU 100/7 clr", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

      // Start pulses at E10 and in the DONE cycle must be ignored.
      @(negedge clk);
      dif.start = 1'b1; dif.signed_op = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
      @(negedge clk);
      dif.start = 1'b0;
      lat = 0;
      while (lat < 9) begin @(negedge clk); lat++; end
      dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd3;
      @(negedge clk);
      lat++;
      dif.start = 1'b0;
      while (!dif.done && lat < 100) begin @(negedge clk); lat++; end
      $display("op ignored-starts: lat=%0d q=%h r=%h", lat, dif.quotient, dif.remainder);
      check("ignore latency", lat, 34);
      check("ignore quotient", dif.quotient, 32'd14);
      check("ignore remainder", dif.remainder, 32'd2);
      pulses = dif.done ? 1 : 0;
      dif.start = 1'b1;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (dif.done) pulses++;
      end
      check("ignore done pulses", pulses, 1);

      // Reset at E12 of an operation.
      @(negedge clk);
      dif.start = 1'b1; dif.signed_op = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
      @(negedge clk);
      dif.start = 1'b0;
      lat = 0;
      while (lat < 11) begin @(negedge clk); lat++; end
      rst_n = 1'b0;
      @(negedge clk);
      $display("op mid-reset: busy=%0d done=%0d q=%h r=%h dz=%0d",
               dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_zero);
      check("midreset outputs", {dif.busy, dif.done, dif.div_zero, dif.quotient, dif.remainder}, 67'h0);
      rst_n = 1'b1;
      run_op("DIVU 50/6", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 34);

      // Randomized traffic, including stray starts and rare resets.
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         dif.start     = ($urandom_range(0, 3) == 0);
         dif.signed_op = $urandom_range(0, 1) == 1;
         dif.dividend  = pick();
         dif.divisor   = pick();
         rst_n         = ($urandom_range(0, 1999) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dif.start = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
